// File: rtl/fifo_write_port_if.sv
// Producer-side valid/ready handshake into the FIFO write port.
interface fifo_write_port_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  w_valid_in;
  logic [DATA_WIDTH-1:0] w_data_in;
  logic                  w_ready_out;

  // Producer drives valid/data and observes ready.
  modport master (
    output w_valid_in,
    output w_data_in,
    input  w_ready_out
  );

  // The write port consumes valid/data and publishes ready.
  modport slave (
    input  w_valid_in,
    input  w_data_in,
    output w_ready_out
  );

endinterface : fifo_write_port_if

// File: rtl/fifo_write_port.sv
// Write-domain half of the asynchronous CDC FIFO: accepts producer words,
// drives the dual-clock memory write port, keeps binary/Gray write pointers,
// synchronises the read Gray pointer and derives full/level/overflow.
module fifo_write_port #(
  parameter int unsigned ADDR_WIDTH         = 3,
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned ALMOST_FULL_THRESH = 6
) (
  input  logic                  w_clk_in,
  input  logic                  w_reset_in,
  fifo_write_port_if.slave      wr_if,
  input  logic [ADDR_WIDTH:0]   r_ptr_gray_in,
  input  logic                  clear_overflow_in,
  output logic                  mem_we_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [ADDR_WIDTH-1:0] w_ptr_out,
  output logic [ADDR_WIDTH:0]   w_ptr_gray_out,
  output logic                  full_out,
  output logic                  almost_full_out,
  output logic [ADDR_WIDTH:0]   level_out,
  output logic                  overflow_out
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  // Elaboration-time parameter sanity checks.
  generate
    if (ADDR_WIDTH < 2) begin : g_bad_addr_width
      $error("fifo_write_port: ADDR_WIDTH must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("fifo_write_port: SYNC_STAGES must be >= 2");
    end
    if ((ALMOST_FULL_THRESH < 1) || (ALMOST_FULL_THRESH > (1 << ADDR_WIDTH))) begin : g_bad_thresh
      $error("fifo_write_port: ALMOST_FULL_THRESH out of range");
    end
  endgenerate

  logic [PTR_W-1:0] w_bin;
  logic [PTR_W-1:0] w_gray;
  logic [PTR_W-1:0] next_bin;
  logic [PTR_W-1:0] next_gray;
  logic [PTR_W-1:0] sync_q [SYNC_STAGES];
  logic [PTR_W-1:0] rq_gray;
  logic [PTR_W-1:0] rq_bin;
  logic [PTR_W-1:0] full_pattern;
  logic             overflow;
  logic             accept;
  logic             overflow_set;

  // Synchronised read pointer is the last stage of the chain.
  assign rq_gray = sync_q[SYNC_STAGES-1];

  // Gray-to-binary decode: each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    rq_bin = '0;
    for (int i = 0; i < int'(PTR_W); i++) begin
      rq_bin[i] = ^(rq_gray >> i);
    end
  end

  // Full when the write pointer has lapped the synchronised read pointer once.
  always_comb begin
    full_pattern = {~rq_gray[ADDR_WIDTH -: 2], rq_gray[ADDR_WIDTH-2:0]};
    full_out     = (w_gray == full_pattern);
  end

  // Occupancy and almost-full, pessimistic because rq_bin lags the reader.
  always_comb begin
    level_out       = w_bin - rq_bin;
    almost_full_out = (level_out >= PTR_W'(ALMOST_FULL_THRESH));
  end

  // Handshake decode; reset suppresses any write in flight.
  always_comb begin
    accept       = wr_if.w_valid_in & ~full_out & ~w_reset_in;
    overflow_set = wr_if.w_valid_in & full_out;
    next_bin     = w_bin + PTR_W'(1);
    next_gray    = next_bin ^ (next_bin >> 1);
  end

  // Memory write port is driven straight from the handshake and pointer.
  always_comb begin
    mem_we_out        = accept;
    mem_addr_out      = w_bin[ADDR_WIDTH-1:0];
    mem_data_out      = wr_if.w_data_in;
    wr_if.w_ready_out = ~full_out;
  end

  // Pointer outputs come directly from the pointer registers.
  always_comb begin
    w_ptr_out      = w_bin[ADDR_WIDTH-1:0];
    w_ptr_gray_out = w_gray;
    overflow_out   = overflow;
  end

  // Binary and Gray write pointers advance together on each accepted word.
  always_ff @(posedge w_clk_in or posedge w_reset_in) begin
    if (w_reset_in) begin
      w_bin  <= '0;
      w_gray <= '0;
    end else if (accept) begin
      w_bin  <= next_bin;
      w_gray <= next_gray;
    end
  end

  // Multi-flop synchroniser bringing the read Gray pointer into this domain.
  always_ff @(posedge w_clk_in or posedge w_reset_in) begin
    if (w_reset_in) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= r_ptr_gray_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Sticky overflow; a fresh overflow beats a same-cycle clear.
  always_ff @(posedge w_clk_in or posedge w_reset_in) begin
    if (w_reset_in) begin
      overflow <= 1'b0;
    end else if (overflow_set) begin
      overflow <= 1'b1;
    end else if (clear_overflow_in) begin
      overflow <= 1'b0;
    end
  end

endmodule : fifo_write_port

// File: doc/fifo_write_port.md
# fifo_write_port

Write-side port of the asynchronous CDC FIFO, clocked entirely in the write domain. It accepts producer data through a valid/ready handshake and drives the dual-clock memory write port. It maintains the binary and Gray write pointers and synchronises the read-domain Gray read pointer into the write domain. From these it derives full, almost-full, fill level and a sticky overflow error, and it publishes the Gray write pointer for the read domain's synchroniser.

## Interface
- ADDR_WIDTH, 3: memory address width; FIFO depth = 2^ADDR_WIDTH; must be >= 2.
- DATA_WIDTH, 8: data word width.
- SYNC_STAGES, 2: flop stages in the read-pointer synchroniser; must be >= 2.
- ALMOST_FULL_THRESH, 6: level at or above which almost_full_out asserts; range 1..2^ADDR_WIDTH.
- w_clk_in  in  1  write clock.
- w_reset_in  in  1  reset, asynchronous, active-high.
- w_valid_in  in  1  producer has a word on w_data_in.
- w_data_in  in  DATA_WIDTH  write data.
- w_ready_out  out  1  port can accept a word; equals !full_out.
- r_ptr_gray_in  in  ADDR_WIDTH+1  Gray read pointer, registered in the read domain.
- clear_overflow_in  in  1  clears overflow_out.
- mem_we_out  out  1  memory write enable.
- mem_addr_out  out  ADDR_WIDTH  memory write address.
- mem_data_out  out  DATA_WIDTH  memory write data.
- w_ptr_out  out  ADDR_WIDTH  binary write pointer, low bits.
- w_ptr_gray_out  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- full_out  out  1  FIFO full.
- almost_full_out  out  1  level_out >= ALMOST_FULL_THRESH.
- level_out  out  ADDR_WIDTH+1  occupancy as seen from the write domain.
- overflow_out  out  1  sticky; a write was attempted while full.

## Operation
- Registers:
  - w_bin, ADDR_WIDTH+1 bits.
  - w_gray, ADDR_WIDTH+1 bits.
  - sync chain of SYNC_STAGES x (ADDR_WIDTH+1) bits.
  - overflow.
- Accept condition: accept = w_valid_in & !full_out & !w_reset_in.
- Memory outputs are combinational:
  - mem_we_out = accept.
  - mem_addr_out = w_bin[ADDR_WIDTH-1:0].
  - mem_data_out = w_data_in.
  - The memory captures the word on the same w_clk_in edge.
- Pointer update on accept:
  - w_bin <= w_bin + 1, wrapping modulo 2^(ADDR_WIDTH+1).
  - w_gray <= next_bin ^ (next_bin >> 1).
  - Without accept, both pointers hold.
- Pointer outputs: w_ptr_out = w_bin[ADDR_WIDTH-1:0]; w_ptr_gray_out = w_gray.
  - Only one bit of w_ptr_gray_out changes per accept.
- Synchroniser:
  - r_ptr_gray_in is shifted through SYNC_STAGES flops; the last stage is rq_gray.
  - rq_bin is the Gray-to-binary decode of rq_gray (prefix XOR from the MSB).
- Full, combinational from registers: full_out = (w_gray == {~rq_gray[A:A-1], rq_gray[A-2:0]}), where A = ADDR_WIDTH.
- Level: level_out = w_bin - rq_bin, computed modulo 2^(ADDR_WIDTH+1); range 0..2^ADDR_WIDTH.
- Almost full: almost_full_out = (level_out >= ALMOST_FULL_THRESH).
- Overflow:
  - w_valid_in & full_out at a clock edge sets overflow. The word is dropped, pointers hold, and mem_we_out stays 0.
  - clear_overflow_in clears overflow.
  - If set and clear occur in the same cycle, set wins.
- Full is pessimistic: the read pointer lags by the synchroniser, so the port may report full while space already exists, but never the reverse.

## Timing
- Reset values:
  - All registers 0.
  - full_out 0, almost_full_out 0, level_out 0, overflow_out 0.
  - w_ptr_out 0, w_ptr_gray_out 0, w_ready_out 1.
  - mem_we_out 0 while w_reset_in is high, regardless of w_valid_in.
- Reset mid-operation: all state clears immediately on assertion, without waiting for a clock. Any write in progress is abandoned. The first accept is possible at the first edge after deassertion.
- Write latency: the word is written at the edge where accept is high. full_out, level_out and almost_full_out reflect that write immediately after the same edge.
- Back-to-back: one accept per cycle sustained while not full.
- Read-pointer latency: a change on r_ptr_gray_in before edge j reaches rq_gray after edge j+SYNC_STAGES-1. full_out, level_out and almost_full_out update in the same cycle as rq_gray.
- Simultaneous accept and read-pointer advance: both take effect independently; level reflects both.

## Test plan
- Reset with w_valid_in=1 -> during reset mem_we_out=0, w_ready_out=1, all other outputs 0. After deassertion, first accept writes addr 0.
- r_ptr_gray_in=0, 8 consecutive valid cycles -> mem_addr_out 0..7 and level 1..8. almost_full_out rises after the 6th write; full_out rises after the 8th. After the 8th write, w_ptr_gray_out=4'b1100 and w_ready_out=0.
- While full, w_valid_in=1 for 1 cycle -> mem_we_out=0, pointer stays 8, overflow_out=1 next edge. clear_overflow_in pulse -> overflow_out=0. Pulsing set and clear together -> overflow_out stays 1.
- From full, drive r_ptr_gray_in=4'b0010 (read pointer 3) -> full_out holds for the 1st edge and clears after the 2nd edge. Then level_out=5 and almost_full_out=0.
- Wrap: advance reads and writes until w_bin wraps 15->0 -> mem_addr_out wraps 7->0 and each w_ptr_gray_out step changes exactly one bit. With w_bin=0 and r_ptr_gray_in=4'b1100 (read pointer 8), full_out=1 and level_out=8.
- Assert w_reset_in mid-burst at level 4 -> outputs return to reset values immediately. Writes resume from addr 0 after deassertion.
